// File: rtl/rv32i_alu_if.sv
// ALU operand/result bundle between the execute stage and the ALU.
// Latency: n/a (wires only); results are combinational plus a registered copy.
// Backpressure: none; a new operation may be presented every cycle.
interface rv32i_alu_if;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic [3:0]  alu_operation;
    logic [31:0] c_o;
    logic        alu_flag;
    logic [31:0] c_q;
    logic        flag_q;

    // Execute stage: drives operands and opcode, consumes results.
    modport master (
        output a_i, b_i, alu_operation,
        input  c_o, alu_flag, c_q, flag_q
    );

    // ALU: consumes operands and opcode, drives results.
    modport slave (
        input  a_i, b_i, alu_operation,
        output c_o, alu_flag, c_q, flag_q
    );
endinterface

// File: rtl/rv32i_alu.sv
// RV32I integer ALU: 32-bit result plus branch/zero flag, with a registered copy.
// Latency: c_o/alu_flag combinational (0 cycles); c_q/flag_q 1 cycle on aclk.
// Backpressure: none; accepts a new operation every cycle, no enable or stall.
module rv32i_alu (
    input  logic         aclk,
    input  logic         aresetn,
    rv32i_alu_if.slave   alu
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_EQ   = 4'd10;
    localparam logic [3:0] OP_NE   = 4'd11;
    localparam logic [3:0] OP_LT   = 4'd12;
    localparam logic [3:0] OP_GE   = 4'd13;
    localparam logic [3:0] OP_LTU  = 4'd14;
    localparam logic [3:0] OP_GEU  = 4'd15;

    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        lt_s;
    logic        lt_u;
    logic        eq;
    logic [31:0] c_dat;
    logic        flag_dat;
    logic        is_cmp;

    assign a     = alu.a_i;
    assign b     = alu.b_i;
    // Shift amount deliberately ignores b[31:5], so shifting by 32 equals shifting by 0.
    assign shamt = b[4:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;
    assign eq    = (a == b);
    assign is_cmp = (alu.alu_operation >= OP_EQ);

    // Result/flag selection: arithmetic/logic ops give a zero flag, compares put the flag in c[0].
    always_comb begin
        c_dat    = 32'd0;
        flag_dat = 1'b0;
        unique case (alu.alu_operation)
            OP_ADD:  c_dat = a + b;
            OP_SUB:  c_dat = a - b;
            OP_SLL:  c_dat = a << shamt;
            OP_SLT:  c_dat = {31'd0, lt_s};
            OP_SLTU: c_dat = {31'd0, lt_u};
            OP_XOR:  c_dat = a ^ b;
            OP_SRL:  c_dat = a >> shamt;
            OP_SRA:  c_dat = $unsigned($signed(a) >>> shamt);
            OP_OR:   c_dat = a | b;
            OP_AND:  c_dat = a & b;
            OP_EQ:   flag_dat = eq;
            OP_NE:   flag_dat = ~eq;
            OP_LT:   flag_dat = lt_s;
            OP_GE:   flag_dat = ~lt_s;
            OP_LTU:  flag_dat = lt_u;
            OP_GEU:  flag_dat = ~lt_u;
            default: c_dat = 32'd0;
        endcase
        if (is_cmp) begin
            c_dat = {31'd0, flag_dat};
        end else begin
            flag_dat = (c_dat == 32'd0);
        end
    end

    assign alu.c_o      = c_dat;
    assign alu.alu_flag = flag_dat;

    // Pipelined copy of the result; synchronous reset clears only the registered outputs.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            alu.c_q    <= 32'd0;
            alu.flag_q <= 1'b0;
        end else begin
            alu.c_q    <= c_dat;
            alu.flag_q <= flag_dat;
        end
    end
endmodule

// File: tb/tb_rv32i_alu.sv
// Directed-vector bench for rv32i_alu: combinational ops and the registered path.
// Latency: checks c_o/alu_flag 1 ns after inputs change, c_q/flag_q 1 ns after the edge.
// Backpressure: none exercised; the ALU has no handshake.
module tb_rv32i_alu;
    logic aclk;
    logic aresetn;
    int   n_checks;
    int   n_errors;

    rv32i_alu_if bus();

    rv32i_alu dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .alu     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Count one comparison and report it if observed differs from expected.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one operation and check both combinational outputs.
    task automatic apply_vec(input string tag, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] exp_c, input logic exp_f);
        bus.alu_operation = op;
        bus.a_i           = a;
        bus.b_i           = b;
        #1;
        chk({tag, ".c"}, bus.c_o, exp_c);
        chk({tag, ".flag"}, {31'd0, bus.alu_flag}, {31'd0, exp_f});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        aresetn  = 1'b0;
        bus.alu_operation = 4'd0;
        bus.a_i = 32'd5;
        bus.b_i = 32'd7;

        // Reset held for two edges: registered outputs cleared, combinational path live.
        @(posedge aclk);
        @(posedge aclk);
        #1;
        chk("rst.c_q", bus.c_q, 32'd0);
        chk("rst.flag_q", {31'd0, bus.flag_q}, 32'd0);
        chk("rst.c_o_live", bus.c_o, 32'd12);

        // Arithmetic wrap
        apply_vec("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        apply_vec("sub_wrap", 4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        // Shifts, including b[31:5] ignored
        apply_vec("sll_33", 4'd2, 32'd1, 32'h0000_0021, 32'd2, 1'b0);
        apply_vec("sll_32", 4'd2, 32'h0000_1234, 32'd32, 32'h0000_1234, 1'b0);
        apply_vec("srl_31", 4'd6, 32'h8000_0000, 32'd31, 32'd1, 1'b0);
        apply_vec("sra_31", 4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0);
        apply_vec("sra_pos", 4'd7, 32'h4000_0000, 32'd4, 32'h0400_0000, 1'b0);
        // Set-less-than with -1 vs 1
        apply_vec("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0);
        apply_vec("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1);
        // Branch compares with -2 vs 2
        apply_vec("eq", 4'd10, 32'hFFFF_FFFE, 32'd2, 32'd0, 1'b0);
        apply_vec("ne", 4'd11, 32'hFFFF_FFFE, 32'd2, 32'd1, 1'b1);
        apply_vec("lt", 4'd12, 32'hFFFF_FFFE, 32'd2, 32'd1, 1'b1);
        apply_vec("ge", 4'd13, 32'hFFFF_FFFE, 32'd2, 32'd0, 1'b0);
        apply_vec("ltu", 4'd14, 32'hFFFF_FFFE, 32'd2, 32'd0, 1'b0);
        apply_vec("geu", 4'd15, 32'hFFFF_FFFE, 32'd2, 32'd1, 1'b1);
        apply_vec("eq_same", 4'd10, 32'd7, 32'd7, 32'd1, 1'b1);
        // Logic ops
        apply_vec("and", 4'd9, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
        apply_vec("or", 4'd8, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0);
        apply_vec("xor", 4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0);
        apply_vec("and_zero", 4'd9, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0, 1'b1);

        // Registered path: release reset, ADD 5+7 captured after one edge.
        @(negedge aclk);
        aresetn = 1'b1;
        bus.alu_operation = 4'd0;
        bus.a_i = 32'd5;
        bus.b_i = 32'd7;
        @(posedge aclk);
        #1;
        chk("reg.c_q", bus.c_q, 32'd12);
        chk("reg.flag_q", {31'd0, bus.flag_q}, 32'd0);

        // Zero result registers the zero flag.
        @(negedge aclk);
        bus.a_i = 32'd0;
        bus.b_i = 32'd0;
        @(posedge aclk);
        #1;
        chk("reg0.c_q", bus.c_q, 32'd0);
        chk("reg0.flag_q", {31'd0, bus.flag_q}, 32'd1);

        // Back to 5+7, then reset mid-stream.
        @(negedge aclk);
        bus.a_i = 32'd5;
        bus.b_i = 32'd7;
        @(posedge aclk);
        #1;
        chk("pre_rst.c_q", bus.c_q, 32'd12);
        @(negedge aclk);
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        chk("mid_rst.c_q", bus.c_q, 32'd0);
        chk("mid_rst.flag_q", {31'd0, bus.flag_q}, 32'd0);
        chk("mid_rst.c_o", bus.c_o, 32'd12);

        // First edge after release captures the live result.
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_rst.c_q", bus.c_q, 32'd12);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
